aq_djpeg_idct_seq: RTL and testbench
====================================

AQ_DJPEG_IDCT_SEQ -- requirements
Module: aq_djpeg_idct_seq

Interface
REQ-001 Parameter OUT_CREDITS, default 2: number of downstream output block slots; legal range 1..3.
REQ-002 Port clk, input, 1: single clock; all logic on rising edge.
REQ-003 Port rst, input, 1: reset is synchronous and active-low.
REQ-004 Port ProcessInit, input, 1: synchronous soft clear, active-high.
REQ-005 Port BankWriteDone, input, 1: one-cycle pulse; writer has filled coefficient bank WrBank.
REQ-006 Port WrBank, output, 1: bank index the writer shall fill next.
REQ-007 Port BankFull, output, 1: both coefficient banks occupied.
REQ-008 Port IdctInEnable, output, 1: drives IDCT DataInEnable.
REQ-009 Port IdctInRead, input, 1: IDCT DataInRead strobe.
REQ-010 Port IdctInAddress, input, 5: IDCT DataInAddress.
REQ-011 Port RdBank, output, 1: bank currently presented to the IDCT.
REQ-012 Port IdctOutEnable, input, 1: IDCT DataOutEnable.
REQ-013 Port IdctOutPage, input, 3: IDCT DataOutPage.
REQ-014 Port IdctOutCount, input, 2: IDCT DataOutCount.
REQ-015 Port OutRelease, input, 1: one-cycle pulse; downstream freed one output slot.
REQ-016 Port BlockDone, output, 1: one-cycle pulse; a full 8x8 block has left the IDCT.
REQ-017 Port InFlight, output, 2: number of blocks started and not yet done.
REQ-018 Port BlockCount, output, 16: completed blocks since init; wraps from 0xFFFF to 0.
REQ-019 Port Overflow, output, 1: sticky error flag.

Function
REQ-020 BankCnt (0..2) shall increment on BankWriteDone, decrement on bank consumed, and stay unchanged when both occur in the same cycle.
REQ-021 WrBank shall toggle on every accepted BankWriteDone; RdBank shall toggle on every bank consumed.
REQ-022 BankFull shall equal (BankCnt==2).
REQ-023 BankWriteDone while BankCnt==2 with no same-cycle consume shall be ignored for all counters and pointers, and shall set Overflow.
REQ-024 Credit counter shall start at OUT_CREDITS; it shall decrement on block start, increment on OutRelease, and stay unchanged when both occur in the same cycle.
REQ-025 OutRelease at Credit==OUT_CREDITS with no same-cycle start shall be ignored and shall set Overflow.
REQ-026 The FSM shall have two states: IDLE and FEED.
REQ-027 IDLE->FEED shall occur when BankCnt>0 and Credit>0; that cycle is the block start; IdctInEnable shall be 1 from the next cycle.
REQ-028 In FEED, IdctInEnable shall stay 1 until the cycle of IdctInRead=1 with IdctInAddress=31.
REQ-029 On the IdctInRead=1, IdctInAddress=31 cycle the bank is consumed; FEED->IDLE; IdctInEnable shall be 0 from the next cycle.
REQ-030 IdctInRead in IDLE shall be ignored.
REQ-031 Back-to-back blocks: from IDLE, a new start is permitted on the cycle after consume; minimum one IDLE cycle between blocks.
REQ-032 InFlight shall increment on start, decrement on BlockDone, and stay unchanged when both occur in the same cycle.
REQ-033 Output beat tracking: the block-end beat is IdctOutEnable=1 with IdctOutPage=7 and IdctOutCount=3.
REQ-034 BlockDone shall pulse the cycle after the block-end beat, and BlockCount shall increment in that same cycle.
REQ-035 A block-end beat while InFlight==0 shall set Overflow and shall not generate BlockDone.
REQ-036 Overflow shall clear only on reset or ProcessInit.

Reset
REQ-037 rst=0 at a rising edge shall force: state IDLE, BankCnt=0, WrBank=0, RdBank=0, Credit=OUT_CREDITS, InFlight=0, BlockCount=0, IdctInEnable=0, BlockDone=0, BankFull=0, Overflow=0.
REQ-038 ProcessInit=1 shall produce the identical result as reset in the same cycle, including in FEED mid-block, and shall take priority over all other inputs.
REQ-039 After ProcessInit, IDCT output beats of an aborted block shall be ignored, per REQ-035, with Overflow held at 0 for 40 cycles after the init.

Verification
REQ-040 Single block: BankWriteDone pulse, then IDCT reads at addresses 0..31 -> IdctInEnable=1 from cycle+2 until the address-31 read; RdBank goes 0->1; BlockDone pulses after the page7/count3 beat; BlockCount=1.
REQ-041 Bank full: three BankWriteDone pulses with no reads -> BankFull=1 after the second pulse; Overflow=1 after the third; WrBank=0.
REQ-042 Credit stall: OUT_CREDITS=2, four banks written, no OutRelease -> exactly 2 starts occur and IdctInEnable stays 0; one OutRelease -> a third start on the next cycle.
REQ-043 Simultaneous events: BankWriteDone coincident with consume at BankCnt=2 -> BankCnt stays 2, no Overflow, both pointers toggle.
REQ-044 Mid-block init: ProcessInit at read address 12 -> next cycle IdctInEnable=0, InFlight=0, Credit=2; later page7/count3 beat -> no BlockDone and Overflow=0.
REQ-045 Wrap: preload BlockCount to 0xFFFF via 65535 blocks or force, one more block -> BlockCount=0x0000.

Source files
------------

// File: rtl/aq_djpeg_idct_seq.sv
// Sequencer between the coefficient double-buffer, the IDCT core and downstream output slots.
// Tracks bank occupancy, output credits, blocks in flight and completed-block count.
module aq_djpeg_idct_seq #(
  parameter int OUT_CREDITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ProcessInit,
  input  logic        BankWriteDone,
  output logic        WrBank,
  output logic        BankFull,
  output logic        IdctInEnable,
  input  logic        IdctInRead,
  input  logic [4:0]  IdctInAddress,
  output logic        RdBank,
  input  logic        IdctOutEnable,
  input  logic [2:0]  IdctOutPage,
  input  logic [1:0]  IdctOutCount,
  input  logic        OutRelease,
  output logic        BlockDone,
  output logic [1:0]  InFlight,
  output logic [15:0] BlockCount,
  output logic        Overflow
);

  localparam logic [1:0] CREDIT_MAX = 2'(OUT_CREDITS);
  // Long enough for the tail of an aborted block to drain out of the IDCT
  localparam logic [5:0] INIT_GUARD = 6'd40;

  typedef enum logic {IDLE = 1'b0, FEED = 1'b1} state_t;

  state_t      state, stateNxt;
  logic [1:0]  bankCnt, bankCntNxt;
  logic [1:0]  credit, creditNxt;
  logic [1:0]  inFlightNxt;
  logic [5:0]  guardCnt, guardCntNxt;
  logic [15:0] blockCountNxt;
  logic        start, consume;
  logic        acceptWrite, writeReject;
  logic        acceptRelease, releaseReject;
  logic        endBeat, doneEvent, orphanBeat;
  logic        wrBankNxt, rdBankNxt, overflowNxt;

  // Next-state logic: a block starts from IDLE and ends on the address-31 read
  always_comb begin
    stateNxt = state;
    start    = 1'b0;
    consume  = 1'b0;
    case (state)
      IDLE: begin
        if (bankCnt != 2'd0 && credit != 2'd0) begin
          start    = 1'b1;
          stateNxt = FEED;
        end else begin
          stateNxt = IDLE;
        end
      end
      FEED: begin
        if (IdctInRead && IdctInAddress == 5'd31) begin
          consume  = 1'b1;
          stateNxt = IDLE;
        end else begin
          stateNxt = FEED;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Bank occupancy, bank pointers and output credits
  always_comb begin
    acceptWrite   = BankWriteDone && (bankCnt != 2'd2 || consume);
    writeReject   = BankWriteDone && !acceptWrite;
    acceptRelease = OutRelease && (credit != CREDIT_MAX || start);
    releaseReject = OutRelease && !acceptRelease;
    wrBankNxt     = WrBank ^ acceptWrite;
    rdBankNxt     = RdBank ^ consume;
    case ({acceptWrite, consume})
      2'b10:   bankCntNxt = bankCnt + 2'd1;
      2'b01:   bankCntNxt = bankCnt - 2'd1;
      default: bankCntNxt = bankCnt;
    endcase
    case ({start, acceptRelease})
      2'b10:   creditNxt = credit - 2'd1;
      2'b01:   creditNxt = credit + 2'd1;
      default: creditNxt = credit;
    endcase
  end

  // Output-side tracking; orphan beats inside the post-init window are dropped silently
  always_comb begin
    endBeat     = IdctOutEnable && IdctOutPage == 3'd7 && IdctOutCount == 2'd3;
    doneEvent   = endBeat && InFlight != 2'd0;
    orphanBeat  = endBeat && InFlight == 2'd0 && guardCnt == 6'd0;
    guardCntNxt = (guardCnt != 6'd0) ? guardCnt - 6'd1 : 6'd0;
    if (doneEvent) begin
      blockCountNxt = BlockCount + 16'd1;
    end else begin
      blockCountNxt = BlockCount;
    end
    case ({start, doneEvent})
      2'b10:   inFlightNxt = InFlight + 2'd1;
      2'b01:   inFlightNxt = InFlight - 2'd1;
      default: inFlightNxt = InFlight;
    endcase
    overflowNxt = Overflow | writeReject | releaseReject | orphanBeat;
  end

  // State and output registers; reset and ProcessInit land in the same clean state
  always_ff @(posedge clk) begin
    if (!rst || ProcessInit) begin
      state        <= IDLE;
      bankCnt      <= 2'd0;
      credit       <= CREDIT_MAX;
      guardCnt     <= INIT_GUARD;
      WrBank       <= 1'b0;
      RdBank       <= 1'b0;
      BankFull     <= 1'b0;
      IdctInEnable <= 1'b0;
      BlockDone    <= 1'b0;
      InFlight     <= 2'd0;
      BlockCount   <= 16'd0;
      Overflow     <= 1'b0;
    end else begin
      state        <= stateNxt;
      bankCnt      <= bankCntNxt;
      credit       <= creditNxt;
      guardCnt     <= guardCntNxt;
      WrBank       <= wrBankNxt;
      RdBank       <= rdBankNxt;
      BankFull     <= (bankCntNxt == 2'd2);
      IdctInEnable <= (stateNxt == FEED);
      BlockDone    <= doneEvent;
      InFlight     <= inFlightNxt;
      BlockCount   <= blockCountNxt;
      Overflow     <= overflowNxt;
    end
  end

endmodule

// File: tb/tb_aq_djpeg_idct_seq.sv
// Scenario bench for aq_djpeg_idct_seq: randomized read/beat timing, expectations from block-level bookkeeping.
module tb_aq_djpeg_idct_seq;

  localparam int OUT_CREDITS = 2;

  logic        clk = 1'b0;
  logic        rst, ProcessInit, BankWriteDone, IdctInRead, IdctOutEnable, OutRelease;
  logic [4:0]  IdctInAddress;
  logic [2:0]  IdctOutPage;
  logic [1:0]  IdctOutCount;
  logic        WrBank, BankFull, IdctInEnable, RdBank, BlockDone, Overflow;
  logic [1:0]  InFlight;
  logic [15:0] BlockCount;

  int vectors = 0;
  int miscompares = 0;
  int expBlocks = 0;

  always #5 clk = ~clk;

  aq_djpeg_idct_seq #(.OUT_CREDITS(OUT_CREDITS)) dut (
    .clk(clk), .rst(rst), .ProcessInit(ProcessInit), .BankWriteDone(BankWriteDone),
    .WrBank(WrBank), .BankFull(BankFull), .IdctInEnable(IdctInEnable),
    .IdctInRead(IdctInRead), .IdctInAddress(IdctInAddress), .RdBank(RdBank),
    .IdctOutEnable(IdctOutEnable), .IdctOutPage(IdctOutPage), .IdctOutCount(IdctOutCount),
    .OutRelease(OutRelease), .BlockDone(BlockDone), .InFlight(InFlight),
    .BlockCount(BlockCount), .Overflow(Overflow)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doInit();
    ProcessInit = 1'b1;
    tick();
    ProcessInit = 1'b0;
  endtask

  task automatic writeBank();
    BankWriteDone = 1'b1;
    tick();
    BankWriteDone = 1'b0;
  endtask

  task automatic waitEnable(input string tag);
    int n;
    n = 0;
    while (IdctInEnable !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    vectors++;
    if (IdctInEnable !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_wait_enable: IdctInEnable=%b required 1 within 64 cycles", tag, IdctInEnable);
    end
  endtask

  // Reads addresses first..last with random idle gaps in between
  task automatic feedReads(input int first, input int last);
    for (int a = first; a <= last; a++) begin
      repeat ($urandom_range(0, 2)) tick();
      IdctInRead    = 1'b1;
      IdctInAddress = 5'(a);
      tick();
      IdctInRead    = 1'b0;
    end
  endtask

  // Drives 32 output beats; the final page7/count3 beat is left applied for the caller's tick
  task automatic driveBeats(input bit gaps);
    logic [2:0] pg;
    logic [1:0] ct;
    for (int b = 0; b < 32; b++) begin
      if (gaps) begin
        IdctOutEnable = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
      end
      if (b == 31) begin
        pg = 3'd7;
        ct = 2'd3;
      end else begin
        pg = 3'($urandom_range(0, 7));
        ct = 2'($urandom_range(0, 3));
        if (pg == 3'd7 && ct == 2'd3) ct = 2'd2;
      end
      IdctOutEnable = 1'b1;
      IdctOutPage   = pg;
      IdctOutCount  = ct;
      if (b != 31) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    BankWriteDone = 1'b1;
    tick();
    tick();
    BankWriteDone = 1'b0;
    vectors += 8;
    if (WrBank !== 1'b0)        begin miscompares++; $display("FAIL reset_wrbank: got %b required 0", WrBank); end
    if (RdBank !== 1'b0)        begin miscompares++; $display("FAIL reset_rdbank: got %b required 0", RdBank); end
    if (BankFull !== 1'b0)      begin miscompares++; $display("FAIL reset_bankfull: got %b required 0", BankFull); end
    if (IdctInEnable !== 1'b0)  begin miscompares++; $display("FAIL reset_enable: got %b required 0", IdctInEnable); end
    if (BlockDone !== 1'b0)     begin miscompares++; $display("FAIL reset_blockdone: got %b required 0", BlockDone); end
    if (InFlight !== 2'd0)      begin miscompares++; $display("FAIL reset_inflight: got %0d required 0", InFlight); end
    if (BlockCount !== 16'd0)   begin miscompares++; $display("FAIL reset_blockcount: got %0h required 0", BlockCount); end
    if (Overflow !== 1'b0)      begin miscompares++; $display("FAIL reset_overflow: got %b required 0", Overflow); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_block();
    doInit();
    expBlocks = 0;
    IdctInRead = 1'b1;
    IdctInAddress = 5'd31;
    tick();
    IdctInRead = 1'b0;
    vectors += 2;
    if (RdBank !== 1'b0)       begin miscompares++; $display("FAIL idle_read_rdbank: got %b required 0", RdBank); end
    if (IdctInEnable !== 1'b0) begin miscompares++; $display("FAIL idle_read_enable: got %b required 0", IdctInEnable); end
    writeBank();
    vectors += 2;
    if (IdctInEnable !== 1'b0) begin miscompares++; $display("FAIL single_enable_c1: got %b required 0", IdctInEnable); end
    if (WrBank !== 1'b1)       begin miscompares++; $display("FAIL single_wrbank: got %b required 1", WrBank); end
    tick();
    vectors += 2;
    if (IdctInEnable !== 1'b1) begin miscompares++; $display("FAIL single_enable_c2: got %b required 1", IdctInEnable); end
    if (InFlight !== 2'd1)     begin miscompares++; $display("FAIL single_inflight: got %0d required 1", InFlight); end
    feedReads(0, 30);
    vectors++;
    if (IdctInEnable !== 1'b1) begin miscompares++; $display("FAIL single_enable_a30: got %b required 1", IdctInEnable); end
    feedReads(31, 31);
    vectors += 2;
    if (IdctInEnable !== 1'b0) begin miscompares++; $display("FAIL single_enable_end: got %b required 0", IdctInEnable); end
    if (RdBank !== 1'b1)       begin miscompares++; $display("FAIL single_rdbank: got %b required 1", RdBank); end
    driveBeats(1'b1);
    tick();
    IdctOutEnable = 1'b0;
    expBlocks++;
    vectors += 3;
    if (BlockDone !== 1'b1)           begin miscompares++; $display("FAIL single_blockdone: got %b required 1", BlockDone); end
    if (BlockCount !== 16'(expBlocks)) begin miscompares++; $display("FAIL single_blockcount: got %0d required %0d", BlockCount, expBlocks); end
    if (InFlight !== 2'd0)            begin miscompares++; $display("FAIL single_inflight_end: got %0d required 0", InFlight); end
    tick();
    vectors++;
    if (BlockDone !== 1'b0) begin miscompares++; $display("FAIL single_blockdone_pulse: got %b required 0", BlockDone); end
  endtask

  task automatic test_bank_full();
    doInit();
    writeBank();
    vectors += 2;
    if (BankFull !== 1'b0) begin miscompares++; $display("FAIL full_w1_bankfull: got %b required 0", BankFull); end
    if (WrBank !== 1'b1)   begin miscompares++; $display("FAIL full_w1_wrbank: got %b required 1", WrBank); end
    writeBank();
    vectors += 2;
    if (BankFull !== 1'b1) begin miscompares++; $display("FAIL full_w2_bankfull: got %b required 1", BankFull); end
    if (Overflow !== 1'b0) begin miscompares++; $display("FAIL full_w2_overflow: got %b required 0", Overflow); end
    writeBank();
    vectors += 3;
    if (Overflow !== 1'b1) begin miscompares++; $display("FAIL full_w3_overflow: got %b required 1", Overflow); end
    if (WrBank !== 1'b0)   begin miscompares++; $display("FAIL full_w3_wrbank: got %b required 0", WrBank); end
    if (BankFull !== 1'b1) begin miscompares++; $display("FAIL full_w3_bankfull: got %b required 1", BankFull); end
    repeat ($urandom_range(1, 5)) tick();
    vectors++;
    if (Overflow !== 1'b1) begin miscompares++; $display("FAIL full_sticky: got %b required 1", Overflow); end
    doInit();
    vectors += 3;
    if (Overflow !== 1'b0)     begin miscompares++; $display("FAIL full_init_overflow: got %b required 0", Overflow); end
    if (BankFull !== 1'b0)     begin miscompares++; $display("FAIL full_init_bankfull: got %b required 0", BankFull); end
    if (IdctInEnable !== 1'b0) begin miscompares++; $display("FAIL full_init_enable: got %b required 0", IdctInEnable); end
  endtask

  task automatic test_release_overflow();
    doInit();
    OutRelease = 1'b1;
    tick();
    OutRelease = 1'b0;
    vectors++;
    if (Overflow !== 1'b1) begin miscompares++; $display("FAIL rel_full_overflow: got %b required 1", Overflow); end
    doInit();
    writeBank();
    OutRelease = 1'b1;
    tick();
    OutRelease = 1'b0;
    vectors++;
    if (Overflow !== 1'b0) begin miscompares++; $display("FAIL rel_with_start_overflow: got %b required 0", Overflow); end
  endtask

  task automatic test_credit_stall();
    doInit();
    for (int k = 0; k < OUT_CREDITS; k++) begin
      writeBank();
      waitEnable("stall");
      feedReads(0, 31);
    end
    writeBank();
    writeBank();
    repeat ($urandom_range(10, 20)) tick();
    vectors += 3;
    if (IdctInEnable !== 1'b0) begin miscompares++; $display("FAIL stall_enable: got %b required 0", IdctInEnable); end
    if (InFlight !== 2'd2)     begin miscompares++; $display("FAIL stall_inflight: got %0d required 2", InFlight); end
    if (BankFull !== 1'b1)     begin miscompares++; $display("FAIL stall_bankfull: got %b required 1", BankFull); end
    OutRelease = 1'b1;
    tick();
    OutRelease = 1'b0;
    vectors++;
    if (IdctInEnable !== 1'b0) begin miscompares++; $display("FAIL stall_rel_enable: got %b required 0", IdctInEnable); end
    tick();
    vectors += 3;
    if (IdctInEnable !== 1'b1) begin miscompares++; $display("FAIL stall_third_enable: got %b required 1", IdctInEnable); end
    if (InFlight !== 2'd3)     begin miscompares++; $display("FAIL stall_third_inflight: got %0d required 3", InFlight); end
    if (Overflow !== 1'b0)     begin miscompares++; $display("FAIL stall_overflow: got %b required 0", Overflow); end
  endtask

  task automatic test_simultaneous();
    doInit();
    writeBank();
    writeBank();
    waitEnable("simul");
    feedReads(0, 30);
    IdctInRead    = 1'b1;
    IdctInAddress = 5'd31;
    BankWriteDone = 1'b1;
    tick();
    IdctInRead    = 1'b0;
    BankWriteDone = 1'b0;
    vectors += 4;
    if (BankFull !== 1'b1) begin miscompares++; $display("FAIL simul_bankfull: got %b required 1", BankFull); end
    if (Overflow !== 1'b0) begin miscompares++; $display("FAIL simul_overflow: got %b required 0", Overflow); end
    if (WrBank !== 1'b1)   begin miscompares++; $display("FAIL simul_wrbank: got %b required 1", WrBank); end
    if (RdBank !== 1'b1)   begin miscompares++; $display("FAIL simul_rdbank: got %b required 1", RdBank); end
  endtask

  task automatic test_back_to_back();
    doInit();
    expBlocks = 0;
    writeBank();
    writeBank();
    waitEnable("b2b");
    feedReads(0, 31);
    vectors++;
    if (IdctInEnable !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_enable: got %b required 0", IdctInEnable); end
    tick();
    vectors += 2;
    if (IdctInEnable !== 1'b1) begin miscompares++; $display("FAIL b2b_second_enable: got %b required 1", IdctInEnable); end
    if (InFlight !== 2'd2)     begin miscompares++; $display("FAIL b2b_inflight: got %0d required 2", InFlight); end
    feedReads(0, 31);
    vectors++;
    if (RdBank !== 1'b0) begin miscompares++; $display("FAIL b2b_rdbank: got %b required 0", RdBank); end
    for (int b = 0; b < 2; b++) begin
      driveBeats(1'b1);
      tick();
      IdctOutEnable = 1'b0;
      expBlocks++;
      vectors += 2;
      if (BlockDone !== 1'b1)            begin miscompares++; $display("FAIL b2b_blockdone: got %b required 1", BlockDone); end
      if (BlockCount !== 16'(expBlocks)) begin miscompares++; $display("FAIL b2b_blockcount: got %0d required %0d", BlockCount, expBlocks); end
    end
    vectors++;
    if (InFlight !== 2'd0) begin miscompares++; $display("FAIL b2b_inflight_end: got %0d required 0", InFlight); end
  endtask

  task automatic test_mid_block_init();
    doInit();
    writeBank();
    waitEnable("midinit");
    feedReads(0, 11);
    IdctInRead    = 1'b1;
    IdctInAddress = 5'd12;
    ProcessInit   = 1'b1;
    tick();
    IdctInRead    = 1'b0;
    ProcessInit   = 1'b0;
    vectors += 4;
    if (IdctInEnable !== 1'b0) begin miscompares++; $display("FAIL midinit_enable: got %b required 0", IdctInEnable); end
    if (InFlight !== 2'd0)     begin miscompares++; $display("FAIL midinit_inflight: got %0d required 0", InFlight); end
    if (WrBank !== 1'b0)       begin miscompares++; $display("FAIL midinit_wrbank: got %b required 0", WrBank); end
    if (BankFull !== 1'b0)     begin miscompares++; $display("FAIL midinit_bankfull: got %b required 0", BankFull); end
    driveBeats(1'b0);
    tick();
    IdctOutEnable = 1'b0;
    vectors += 3;
    if (BlockDone !== 1'b0)   begin miscompares++; $display("FAIL midinit_blockdone: got %b required 0", BlockDone); end
    if (Overflow !== 1'b0)    begin miscompares++; $display("FAIL midinit_overflow: got %b required 0", Overflow); end
    if (BlockCount !== 16'd0) begin miscompares++; $display("FAIL midinit_blockcount: got %0d required 0", BlockCount); end
    for (int k = 0; k < OUT_CREDITS; k++) begin
      writeBank();
      waitEnable("midinit_credit");
      feedReads(0, 31);
    end
    writeBank();
    repeat (5) tick();
    vectors += 2;
    if (IdctInEnable !== 1'b0) begin miscompares++; $display("FAIL midinit_credit_enable: got %b required 0", IdctInEnable); end
    if (InFlight !== 2'd2)     begin miscompares++; $display("FAIL midinit_credit_inflight: got %0d required 2", InFlight); end
  endtask

  task automatic test_orphan_beat();
    doInit();
    repeat (45) tick();
    IdctOutEnable = 1'b1;
    IdctOutPage   = 3'd7;
    IdctOutCount  = 2'd3;
    tick();
    IdctOutEnable = 1'b0;
    vectors += 2;
    if (BlockDone !== 1'b0) begin miscompares++; $display("FAIL orphan_blockdone: got %b required 0", BlockDone); end
    if (Overflow !== 1'b1)  begin miscompares++; $display("FAIL orphan_overflow: got %b required 1", Overflow); end
  endtask

  task automatic test_wrap();
    doInit();
    force dut.BlockCount = 16'hFFFF;
    tick();
    release dut.BlockCount;
    tick();
    vectors++;
    if (BlockCount !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload: got %0h required ffff", BlockCount); end
    writeBank();
    waitEnable("wrap");
    feedReads(0, 31);
    driveBeats(1'b1);
    tick();
    IdctOutEnable = 1'b0;
    vectors += 2;
    if (BlockDone !== 1'b1)      begin miscompares++; $display("FAIL wrap_blockdone: got %b required 1", BlockDone); end
    if (BlockCount !== 16'h0000) begin miscompares++; $display("FAIL wrap_blockcount: got %0h required 0", BlockCount); end
  endtask

  initial begin
    rst = 1'b1;
    ProcessInit = 1'b0;
    BankWriteDone = 1'b0;
    IdctInRead = 1'b0;
    IdctInAddress = 5'd0;
    IdctOutEnable = 1'b0;
    IdctOutPage = 3'd0;
    IdctOutCount = 2'd0;
    OutRelease = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_block();
    test_bank_full();
    test_release_overflow();
    test_credit_stall();
    test_simultaneous();
    test_back_to_back();
    test_mid_block_init();
    test_orphan_beat();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
